core3_led_pio: RTL

//  Avalon-MM slave output PIO: CPU writes drive a registered parallel port (board LEDs).

---
 rtl/core3_pio_pkg.sv | 22 ++
 rtl/core3_blink_prescaler.sv | 48 ++++
 rtl/core3_led_pio.sv | 93 +++++++++
 3 files changed

// File: rtl/core3_pio_pkg.sv
// Shared PIO definitions: register word addresses and readdata zero-extend.
// Imported by the LED output PIO and the switch input PIO.
package core3_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  // Keep only the low w bits of v (w in 1..32).
  function automatic logic [31:0] pio_zext(
    input logic [31:0] v,
    input int unsigned w
  );
    logic [31:0] m;
    m = (w >= 32) ? '1 : ((32'h1 << w) - 32'h1);
    return v & m;
  endfunction

endpackage

// File: rtl/core3_blink_prescaler.sv
// Blink prescaler: toggles phase every `period` clocks; period 0 disables.
// Ports: clk, reset_n, period, clear (period write), cnt, phase, phase_next.
module core3_blink_prescaler #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                clear,
  output logic [PERIOD_W-1:0] cnt,
  output logic                phase,
  output logic                phase_next
);

  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

  logic [PERIOD_W-1:0] cnt_next;
  logic                terminal;

  // period != 0 is checked first, so period-1 never wraps when used.
  assign terminal = (cnt == (period - ONE));

  always_comb begin
    cnt_next   = '0;
    phase_next = 1'b0;
    if (clear || period == '0) begin
      cnt_next   = '0;
      phase_next = 1'b0;
    end else if (terminal) begin
      cnt_next   = '0;
      phase_next = ~phase;
    end else begin
      cnt_next   = cnt + ONE;
      phase_next = phase;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      phase <= phase_next;
    end
  end

endmodule

// File: rtl/core3_led_pio.sv
// Avalon-MM LED output PIO with atomic set/clear and masked hardware blink.
// Ports: clk, reset_n, address, chipselect, write_n, writedata, readdata, out_port.
module core3_led_pio
  import core3_pio_pkg::*;
#(
  parameter int               WIDTH       = 18,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PERIOD_W    = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]    data_q, data_next;
  logic [WIDTH-1:0]    mask_q, mask_next;
  logic [PERIOD_W-1:0] period_q, period_next;
  logic [PERIOD_W-1:0] cnt_q;
  logic                phase_q, phase_next;
  logic [31:0]         rd_mux;
  logic                wr;
  logic                wr_period;
  logic [WIDTH-1:0]    wdata;
  logic                unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wr_period = wr && (address == ADDR_PERIOD);
  assign wdata     = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    data_next   = data_q;
    mask_next   = mask_q;
    period_next = period_q;
    if (wr) begin
      unique case (address)
        ADDR_DATA:     data_next   = wdata;
        ADDR_MASK:     mask_next   = wdata;
        ADDR_PERIOD:   period_next = writedata[PERIOD_W-1:0];
        ADDR_OUTSET:   data_next   = data_q | wdata;
        ADDR_OUTCLEAR: data_next   = data_q & ~wdata;
        default:       ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      ADDR_DATA:   rd_mux = pio_zext(32'(data_q), WIDTH);
      ADDR_MASK:   rd_mux = pio_zext(32'(mask_q), WIDTH);
      ADDR_PERIOD: rd_mux = pio_zext(32'(period_q), PERIOD_W);
      ADDR_STATUS: rd_mux = {31'b0, phase_q};
      default:     rd_mux = '0;
    endcase
  end

  core3_blink_prescaler #(
    .PERIOD_W (PERIOD_W)
  ) u_prescaler (
    .clk        (clk),
    .reset_n    (reset_n),
    .period     (period_q),
    .clear      (wr_period),
    .cnt        (cnt_q),
    .phase      (phase_q),
    .phase_next (phase_next)
  );

  // out_port is built from next-state values so it moves on the same
  // edge as the registers that feed it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      mask_q   <= '0;
      period_q <= '0;
      readdata <= '0;
      out_port <= RESET_VALUE;
    end else begin
      data_q   <= data_next;
      mask_q   <= mask_next;
      period_q <= period_next;
      readdata <= rd_mux;
      out_port <= data_next ^ (mask_next & {WIDTH{phase_next}});
    end
  end

endmodule
